mul_arbiter: RTL and testbench

MUL_ARBITER -- requirements
Module: mul_arbiter

---
 rtl/mul_arbiter.sv | 78 +++++++
 tb/tb_mul_arbiter.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/mul_arbiter.sv
// mul_arbiter: round-robin arbiter sharing one multiplier between two requesters, with a done timeout.
module mul_arbiter #(
  parameter int TMO_CYC = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic        req1,
  input  logic [15:0] a0,
  input  logic [15:0] a1,
  input  logic [15:0] b0,
  input  logic [15:0] b1,
  output logic        ack0,
  output logic        ack1,
  output logic [31:0] res,
  output logic        err,
  output logic        busy,
  output logic [15:0] mul_a,
  output logic [15:0] mul_b,
  output logic        mul_st,
  input  logic        mul_idle,
  input  logic        mul_done,
  input  logic [31:0] mul_p
);
  localparam int CW = $clog2(TMO_CYC + 1);
  typedef enum logic [1:0] {IDLE, START, BUSY, RESP} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic gnt, last, sel, tmo;
  assign sel = (req0 & req1) ? ~last : req1;
  assign tmo = cnt == CW'(TMO_CYC - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      gnt    <= 1'b0;
      last   <= 1'b1;
      ack0   <= 1'b0;
      ack1   <= 1'b0;
      res    <= '0;
      err    <= 1'b0;
      busy   <= 1'b0;
      mul_a  <= '0;
      mul_b  <= '0;
      mul_st <= 1'b0;
    end else
      case (state)
        IDLE: if ((req0 | req1) & mul_idle) begin
          gnt    <= sel;
          mul_a  <= sel ? a1 : a0;
          mul_b  <= sel ? b1 : b0;
          mul_st <= 1'b1;
          busy   <= 1'b1;
          state  <= START;
        end
        START: begin
          mul_st <= 1'b0;
          cnt    <= '0;
          state  <= BUSY;
        end
        BUSY: if (mul_done | tmo) begin
          res   <= mul_done ? mul_p : '0;
          err   <= ~mul_done;
          ack0  <= ~gnt;
          ack1  <= gnt;
          state <= RESP;
        end else cnt <= cnt + CW'(1);
        RESP: begin
          ack0  <= 1'b0;
          ack1  <= 1'b0;
          err   <= 1'b0;
          busy  <= 1'b0;
          last  <= gnt;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_mul_arbiter.sv
// tb_mul_arbiter: directed scoreboard bench for mul_arbiter with a delay-programmable multiplier model.
module tb_mul_arbiter;
  logic clk = 0, rst_n = 0, req0 = 0, req1 = 0, mul_idle = 1, stray = 0, never = 0;
  logic [15:0] a0 = 0, a1 = 0, b0 = 0, b1 = 0, mul_a, mul_b;
  logic ack0, ack1, err, busy, mul_st, mul_done;
  logic [31:0] res, mul_p;
  int errors = 0, checks = 0, ack_cnt = 0, st_cnt = 0, cyc = 0, st_cyc = 0, ack_cyc = 0, dly = 18;
  int s0, n0;
  logic [33:0] sb[$];
  logic [33:0] e;
  logic m_act = 0, prev_ack = 0;
  int m_cnt = 0;

  always #5 clk = ~clk;

  mul_arbiter #(.TMO_CYC(64)) dut (
    .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1),
    .a0(a0), .a1(a1), .b0(b0), .b1(b1),
    .ack0(ack0), .ack1(ack1), .res(res), .err(err), .busy(busy),
    .mul_a(mul_a), .mul_b(mul_b), .mul_st(mul_st),
    .mul_idle(mul_idle), .mul_done(mul_done), .mul_p(mul_p)
  );

  assign mul_p = mul_a * mul_b;
  assign mul_done = (m_act && m_cnt == 0 && !never) || stray;

  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m_act <= 0;
      m_cnt <= 0;
    end else if (mul_st) begin
      m_act <= 1;
      m_cnt <= dly;
    end else if (m_act) begin
      if (m_cnt == 0) m_act <= 0;
      else m_cnt <= m_cnt - 1;
    end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ctrl"}, {ack0, ack1, err, busy, mul_st}, 0);
    chk({tag, "_res"}, res, 0);
    chk({tag, "_ops"}, {mul_a, mul_b}, 0);
  endtask

  task automatic wait_acks(input int n, input int budget, input string tag);
    int t = 0;
    int target = ack_cnt + n;
    while (ack_cnt < target && t < budget) begin
      @(negedge clk);
      #1;
      t++;
    end
    chk(tag, ack_cnt >= target, 1);
  endtask

  always @(negedge clk)
    if (rst_n) begin
      if (mul_st) begin
        st_cnt++;
        st_cyc = cyc;
      end
      if (prev_ack) chk("idle_gap_busy", busy, 0);
      prev_ack = ack0 | ack1;
      if (ack0 | ack1) begin
        ack_cnt++;
        ack_cyc = cyc;
        chk("one_hot_ack", ack0 & ack1, 0);
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $error("FAIL unexpected_ack observed ack1=%0b res=%0h err=%0b expected no ack", ack1, res, err);
        end else begin
          e = sb.pop_front();
          chk("ack_id", ack1, e[33]);
          chk("res", res, e[32:1]);
          chk("err", err, e[0]);
        end
      end else chk("err_without_ack", err, 0);
    end

  initial begin
    #500000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst_n = 1;
    // both requesters held: priority to 0 after reset, then alternate
    dly = 2;
    a0 = 2; b0 = 2; a1 = 16'hFFFF; b1 = 16'hFFFF;
    sb.push_back({1'b0, 32'd4, 1'b0});
    sb.push_back({1'b1, 32'hFFFE0001, 1'b0});
    sb.push_back({1'b0, 32'd4, 1'b0});
    req0 = 1; req1 = 1;
    wait_acks(3, 300, "t033_acks");
    req0 = 0; req1 = 0;
    // single request, done after 18 busy cycles
    dly = 18;
    a0 = 3; b0 = 5;
    sb.push_back({1'b0, 32'd15, 1'b0});
    s0 = st_cnt;
    req0 = 1;
    wait_acks(1, 100, "t032_ack");
    req0 = 0;
    chk("t032_st_pulses", st_cnt - s0, 1);
    chk("t032_latency", ack_cyc - st_cyc, 20);
    // multiplier never completes -> timeout
    never = 1;
    a1 = 7; b1 = 9;
    sb.push_back({1'b1, 32'd0, 1'b1});
    req1 = 1;
    wait_acks(1, 200, "t034_ack");
    req1 = 0;
    never = 0;
    chk("t034_latency", ack_cyc - st_cyc, 65);
    // done coincides with the timeout cycle; operand change after grant
    dly = 63;
    a0 = 100; b0 = 200;
    sb.push_back({1'b0, 32'd20000, 1'b0});
    req0 = 1;
    repeat (5) @(negedge clk);
    a0 = 16'h1234; b0 = 16'h0077;
    #1;
    chk("t037_mul_a_busy", mul_a, 100);
    wait_acks(1, 200, "t037_ack");
    req0 = 0;
    chk("t037_latency", ack_cyc - st_cyc, 65);
    chk("t037_mul_b_resp", mul_b, 200);
    // multiplier not idle: no grant until it is
    mul_idle = 0;
    a1 = 11; b1 = 13;
    s0 = st_cnt;
    req1 = 1;
    repeat (10) @(negedge clk);
    #1;
    chk("t036_no_st", st_cnt - s0, 0);
    chk("t036_not_busy", busy, 0);
    dly = 3;
    sb.push_back({1'b1, 32'd143, 1'b0});
    mul_idle = 1;
    wait_acks(1, 100, "t036_ack");
    req1 = 0;
    // stray done while idle is ignored
    n0 = ack_cnt;
    @(negedge clk);
    stray = 1;
    @(negedge clk);
    stray = 0;
    repeat (3) @(negedge clk);
    #1;
    chk("t027_no_ack", ack_cnt, n0);
    chk("t027_not_busy", busy, 0);
    // reset in BUSY abandons the operation
    dly = 30;
    a1 = 5; b1 = 6;
    n0 = ack_cnt;
    req1 = 1;
    repeat (8) @(negedge clk);
    #2;
    rst_n = 0;
    #1;
    chk_zero("t035_async");
    repeat (3) @(negedge clk);
    #1;
    chk_zero("t035_held");
    chk("t035_no_ack", ack_cnt, n0);
    sb.push_back({1'b1, 32'd30, 1'b0});
    rst_n = 1;
    wait_acks(1, 100, "t035_ack_after_release");
    req1 = 0;
    repeat (3) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
